// File: rtl/mst_pref_sched.sv
// Round-robin burst scheduler: NCH pre-fetch channels onto one master TX word path.
// Define MST_SCHED_PRIO_EN to give channel 0 precedence at every grant decision.
module mst_pref_sched #(
    parameter int NCH      = 4,
    parameter int CHBIT    = 2,
    parameter int WIDTH    = 17,
    parameter int BURSTLEN = 8,
    parameter int BLBIT    = 3,
    parameter int TMO      = 15,
    parameter int TBIT     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     chena,
    input  logic [NCH-1:0]     prefvld,
    input  logic [NCH*WIDTH-1:0] prefdat,
    output logic [NCH-1:0]     prefena,
    output logic [NCH-1:0]     prefreq,
    input  logic               txrdy,
    output logic               txvld,
    output logic [WIDTH-1:0]   txdat,
    output logic [CHBIT-1:0]   txch,
    output logic               txlast,
    output logic               txtrunc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [CHBIT-1:0] ptr_q;
    logic [CHBIT-1:0] gnt_q;
    logic [BLBIT-1:0] beat_q;
    logic [TBIT-1:0]  tmo_q;
    logic             trunc_q;

    logic [NCH-1:0]   elig;
    logic [CHBIT-1:0] pick;
    logic [CHBIT-1:0] idx;
    logic             found;
    logic             in_burst;
    logic             cur_vld;
    logic             xfer;
    logic [CHBIT-1:0] ptr_d;
    logic [BLBIT-1:0] beat_d;
    logic [TBIT-1:0]  tmo_d;

    assign elig     = chena & prefvld;
    assign prefena  = chena;
    assign in_burst = (state_q == S_BURST);
    assign cur_vld  = prefvld[gnt_q];
    assign txvld    = in_burst & cur_vld;
    assign xfer     = txvld & txrdy;
    assign txdat    = in_burst ? prefdat[gnt_q*WIDTH +: WIDTH] : '0;
    assign txch     = gnt_q;
    assign prefreq  = xfer ? (NCH'(1) << gnt_q) : '0;
    assign txlast   = xfer & (beat_q == BLBIT'(BURSTLEN - 1));
    assign txtrunc  = trunc_q;
    assign ptr_d    = gnt_q + 1'b1;
    assign beat_d   = beat_q + 1'b1;
    assign tmo_d    = tmo_q + 1'b1;

    // First eligible channel at or after ptr, wrapping modulo NCH
    always_comb begin
        pick  = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr_q + CHBIT'(k);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
`ifdef MST_SCHED_PRIO_EN
        if (elig[0]) begin
            pick = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|elig) begin
                        gnt_q   <= pick;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (xfer) begin
                        beat_q <= beat_d;
                        tmo_q  <= '0;
                        if (txlast) begin
                            state_q <= S_GAP;
                        end
                    end else if (!cur_vld) begin
                        tmo_q <= tmo_d;
                        if (tmo_d == TBIT'(TMO)) begin
                            state_q <= S_GAP;
                            trunc_q <= 1'b1;
                        end
                    end else begin
                        // stalled by TX backpressure, not by an empty FIFO
                        tmo_q <= '0;
                    end
                end
                S_GAP: begin
                    ptr_q   <= ptr_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mst_pref_sched.sv
// Directed self-checking bench for mst_pref_sched.
// Covers bursts, round-robin order, timeout, backpressure and mid-burst reset.
module tb_mst_pref_sched;

    localparam logic [16:0] D0 = 17'h0A5A5;
    localparam logic [16:0] D1 = 17'h13C3C;
    localparam logic [16:0] D2 = 17'h05F0F;
    localparam logic [16:0] D3 = 17'h1E1E1;

    logic        clk;
    logic        rst_n;
    logic [3:0]  chena;
    logic [3:0]  prefvld;
    logic [67:0] prefdat;
    logic [3:0]  prefena;
    logic [3:0]  prefreq;
    logic        txrdy;
    logic        txvld;
    logic [16:0] txdat;
    logic [1:0]  txch;
    logic        txlast;
    logic        txtrunc;

    int npass;
    int nchk;

    mst_pref_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .chena   (chena),
        .prefvld (prefvld),
        .prefdat (prefdat),
        .prefena (prefena),
        .prefreq (prefreq),
        .txrdy   (txrdy),
        .txvld   (txvld),
        .txdat   (txdat),
        .txch    (txch),
        .txlast  (txlast),
        .txtrunc (txtrunc)
    );

    assign prefdat = {D3, D2, D1, D0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] dv(input int ch);
        case (ch)
            0: dv = D0;
            1: dv = D1;
            2: dv = D2;
            default: dv = D3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int ch, input int b);
        #4;
        chk("beat_vld", 32'(txvld), 1);
        chk("beat_ch", 32'(txch), 32'(ch));
        chk("beat_dat", 32'(txdat), 32'(dv(ch)));
        chk("beat_req", 32'(prefreq), 32'(1 << ch));
        chk("beat_last", 32'(txlast), 32'(b == 7));
        nxt();
    endtask

    task automatic burst_from(input int ch, input int b0);
        for (int b = b0; b < 8; b++) beat(ch, b);
        #4;
        chk("gap_vld", 32'(txvld), 0);
        chk("gap_req", 32'(prefreq), 0);
        chk("gap_trunc", 32'(txtrunc), 0);
        nxt();
        #4;
        chk("idle_vld", 32'(txvld), 0);
        chk("idle_trunc", 32'(txtrunc), 0);
        nxt();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, 32'(txvld), 0);
        chk({tag, "_req"}, 32'(prefreq), 0);
        chk({tag, "_dat"}, 32'(txdat), 0);
        chk({tag, "_ch"}, 32'(txch), 0);
        chk({tag, "_last"}, 32'(txlast), 0);
        chk({tag, "_trunc"}, 32'(txtrunc), 0);
    endtask

    initial begin
        npass   = 0;
        nchk    = 0;
        rst_n   = 1'b0;
        chena   = 4'b0001;
        prefvld = 4'b0001;
        txrdy   = 1'b1;

        // 1: single channel, back-to-back bursts on ch0
        nxt();
        nxt();
        #4;
        chk_zero("rst");
        chk("rst_prefena", 32'(prefena), 32'h1);
        rst_n = 1'b1;
        nxt();
        burst_from(0, 0);
        burst_from(0, 0);

        // 2: all channels, round-robin 0,1,2,3,0
        chena   = 4'hF;
        prefvld = 4'hF;
        #1;
        chk("prefena_all", 32'(prefena), 32'hF);
        burst_from(0, 0);
        burst_from(1, 0);
        burst_from(2, 0);
        burst_from(3, 0);
        burst_from(0, 0);

        // 3: ch2 starves after 3 words, truncated after 15 idle cycles
        burst_from(1, 0);
        for (int b = 0; b < 3; b++) beat(2, b);
        prefvld = 4'b1011;
        for (int k = 0; k < 15; k++) begin
            #4;
            chk("starve_vld", 32'(txvld), 0);
            chk("starve_req", 32'(prefreq), 0);
            chk("starve_trunc", 32'(txtrunc), 0);
            nxt();
        end
        #4;
        chk("trunc_pulse", 32'(txtrunc), 1);
        chk("trunc_last", 32'(txlast), 0);
        chk("trunc_vld", 32'(txvld), 0);
        nxt();
        #4;
        chk("trunc_end", 32'(txtrunc), 0);
        nxt();
        for (int b = 0; b < 3; b++) beat(3, b);
        prefvld = 4'hF;
        burst_from(3, 3);

        // 4: 30 cycles of TX backpressure on ch0 beat 3
        for (int b = 0; b < 3; b++) beat(0, b);
        txrdy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            #4;
            chk("bp_vld", 32'(txvld), 1);
            chk("bp_ch", 32'(txch), 0);
            chk("bp_dat", 32'(txdat), 32'(D0));
            chk("bp_req", 32'(prefreq), 0);
            chk("bp_last", 32'(txlast), 0);
            chk("bp_trunc", 32'(txtrunc), 0);
            nxt();
        end
        txrdy = 1'b1;
        burst_from(0, 3);

        // 5: asynchronous reset during beat 5 of a ch1 burst
        for (int b = 0; b < 5; b++) beat(1, b);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        nxt();
        #4;
        rst_n = 1'b1;
        nxt();
        burst_from(0, 0);

`ifdef MST_SCHED_PRIO_EN
        // 6: ch0 wins whenever eligible, otherwise round-robin continues
        for (int b = 0; b < 8; b++) beat(0, b);
        prefvld = 4'b1110;
        #4;
        chk("prio_gap_vld", 32'(txvld), 0);
        nxt();
        nxt();
        prefvld = 4'hF;
        burst_from(1, 0);
        #4;
        chk("prio_ch0", 32'(txch), 0);
        chk("prio_vld", 32'(txvld), 1);
`else
        // 6: no precedence for ch0, order continues 1,2
        burst_from(1, 0);
        #4;
        chk("rr_ch2", 32'(txch), 2);
        chk("rr_vld", 32'(txvld), 1);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
